us_distance_filter: RTL and testbench

Downstream stage of the ultrasonic echo measurement block. It takes raw echo pulse widths in clock cycles, converts each to centimetres with a sequential divider, and clamps the result. It smooths readings with a power-of-two moving average and drives a hysteretic proximity flag. Its outputs feed the LED/display logic and the game controller in place of the raw distance counter.

---
 rtl/us_pkg.sv | 18 +
 rtl/us_divider.sv | 71 +++++++
 rtl/us_distance_filter.sv | 190 +++++++++++++++++++
 tb/tb_us_distance_filter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/us_pkg.sv
// us_pkg: shared types and default constants for the ultrasonic distance path.
//   dist_t            16-bit distance in centimetres
//   state_e           filter FSM states
//   CYC_PER_CM_50MHZ  round-trip echo cycles per cm at 50 MHz
//   MAX_CM            range clamp / timeout substitute value
package us_pkg;
   typedef logic [15:0] dist_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_ACC  = 2'd2,
      ST_OUT  = 2'd3
   } state_e;

   localparam int CYC_PER_CM_50MHZ = 2900;
   localparam int MAX_CM           = 400;
endpackage

// File: rtl/us_divider.sv
// us_divider: 32-iteration restoring divider, one quotient bit per cycle.
//   clk, reset_n   clock, synchronous active-low reset
//   start_i        load dividend and begin (ignored bits: none)
//   dividend_i     32-bit dividend
//   divisor_i      16-bit divisor (non-zero)
//   busy_o         iterations in progress
//   done_o         high during the final iteration; quotient_o is valid
//                  from the following cycle
//   quotient_o     registered quotient (remainder discarded)
module us_divider
   import us_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start_i,
   input  logic [31:0] dividend_i,
   input  dist_t       divisor_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] quotient_o
);
   // quo_q starts as the dividend and shifts left; quotient bits enter at
   // the bottom while dividend bits leave the top into the remainder.
   logic [31:0] quo_q, quo_d;
   logic [15:0] rem_q, rem_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [16:0] trial;

   always_comb begin
      quo_d  = quo_q;
      rem_d  = rem_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      trial  = {rem_q, quo_q[31]};
      if (start_i) begin
         quo_d  = dividend_i;
         rem_d  = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (trial >= {1'b0, divisor_i}) begin
            rem_d = 16'(trial - {1'b0, divisor_i});
            quo_d = {quo_q[30:0], 1'b1};
         end else begin
            rem_d = trial[15:0];
            quo_d = {quo_q[30:0], 1'b0};
         end
         cnt_d = cnt_q + 5'd1;
         if (cnt_q == 5'd31) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         quo_q  <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = busy_q && (cnt_q == 5'd31);
   assign quotient_o = quo_q;
endmodule

// File: rtl/us_distance_filter.sv
// us_distance_filter: echo width -> cm conversion, clamp, power-of-two
// moving average and hysteretic proximity flag.
//   clk, reset_n   clock, synchronous active-low reset
//   echo_cycles    echo high time in clk cycles
//   echo_timeout   sample carries no echo; MAX_CM substituted
//   echo_valid     sample offered / echo_ready: block idle, can accept
//   dist_cm        averaged distance, dist_valid one-cycle update strobe
//   near           proximity flag (set <= NEAR_CM, clear >= FAR_CM)
//   filled         window holds 2^N_LOG2 samples
//   spike          one-cycle outlier-reject strobe
// Optional feature: define US_SPIKE_REJECT_EN to enable outlier rejection;
// without it every sample is accepted and spike stays 0.
module us_distance_filter #(
   parameter int CYC_PER_CM = us_pkg::CYC_PER_CM_50MHZ,
   parameter int N_LOG2     = 3,
   parameter int MAX_CM     = us_pkg::MAX_CM,
   parameter int NEAR_CM    = 20,
   parameter int FAR_CM     = 25,
   parameter int SPIKE_CM   = 50
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [31:0]   echo_cycles,
   input  logic          echo_timeout,
   input  logic          echo_valid,
   output logic          echo_ready,
   output us_pkg::dist_t dist_cm,
   output logic          dist_valid,
   output logic          near,
   output logic          filled,
   output logic          spike
);
   import us_pkg::*;

   localparam int                DEPTH   = 1 << N_LOG2;
   localparam int                SW      = 16 + N_LOG2;
   localparam dist_t             MAX_V   = dist_t'(MAX_CM);
   localparam logic [N_LOG2:0]   FULL    = {1'b1, {N_LOG2{1'b0}}};
   localparam logic [N_LOG2:0]   CNT_ONE = 1;
   localparam logic [N_LOG2-1:0] PTR_ONE = 1;

   state_e              state_q, state_d;
   dist_t               ring_q [DEPTH];
   logic [N_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [N_LOG2:0]     cnt_q, cnt_d;
   logic [SW-1:0]       sum_q, sum_d;
   logic                tmo_q, tmo_d, acc_ok_q, acc_ok_d;
   dist_t               dist_q, dist_d;
   logic                dv_q, dv_d, near_q, near_d, filled_q, filled_d;
   logic                spike_q, spike_d, rdy_q;
   logic [2:0]          rej_q, rej_d;
   logic                div_start, div_done, unused_div_busy;
   logic [31:0]         quo;
   dist_t               raw, avg;
   logic                reject, ring_we;

   us_divider u_div (
      .clk        (clk),
      .reset_n    (reset_n),
      .start_i    (div_start),
      .dividend_i (echo_cycles),
      .divisor_i  (dist_t'(CYC_PER_CM)),
      .busy_o     (unused_div_busy),
      .done_o     (div_done),
      .quotient_o (quo)
   );

   always_comb begin
      if (tmo_q || quo > 32'(MAX_CM)) raw = MAX_V;
      else                            raw = quo[15:0];
   end

   assign avg = dist_t'(sum_q >> N_LOG2);

`ifdef US_SPIKE_REJECT_EN
   dist_t dev;
   assign dev    = (raw > dist_q) ? raw - dist_q : dist_q - raw;
   // rej_q == 3 means three outliers in a row were dropped: take the 4th.
   assign reject = filled_q && (dev > dist_t'(SPIKE_CM)) && (rej_q != 3'd3);
`else
   logic unused_spike_cfg;
   assign unused_spike_cfg = ^dist_t'(SPIKE_CM);
   assign reject           = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      tmo_d     = tmo_q;
      acc_ok_d  = acc_ok_q;
      dist_d    = dist_q;
      near_d    = near_q;
      filled_d  = filled_q;
      rej_d     = rej_q;
      dv_d      = 1'b0;
      spike_d   = 1'b0;
      div_start = 1'b0;
      ring_we   = 1'b0;
      unique case (state_q)
         ST_IDLE: if (echo_valid) begin
            tmo_d = echo_timeout;
            if (echo_timeout) state_d = ST_ACC;
            else begin
               div_start = 1'b1;
               state_d   = ST_DIV;
            end
         end
         ST_DIV: if (div_done) state_d = ST_ACC;
         ST_ACC: begin
            state_d  = ST_OUT;
            acc_ok_d = !reject;
            if (reject) begin
               rej_d   = rej_q + 3'd1;
               spike_d = 1'b1;
            end else begin
               // Oldest slot leaves the sum as the new sample replaces it.
               ring_we  = 1'b1;
               sum_d    = sum_q - {{N_LOG2{1'b0}}, ring_q[wr_ptr_q]}
                                + {{N_LOG2{1'b0}}, raw};
               wr_ptr_d = wr_ptr_q + PTR_ONE;
               if (cnt_q != FULL) cnt_d = cnt_q + CNT_ONE;
               rej_d    = '0;
            end
         end
         ST_OUT: begin
            state_d = ST_IDLE;
            if (acc_ok_q) begin
               dist_d = avg;
               if (cnt_q == FULL) begin
                  filled_d = 1'b1;
                  dv_d     = 1'b1;
                  if (avg <= dist_t'(NEAR_CM))     near_d = 1'b1;
                  else if (avg >= dist_t'(FAR_CM)) near_d = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         sum_q    <= '0;
         tmo_q    <= 1'b0;
         acc_ok_q <= 1'b0;
         dist_q   <= '0;
         near_q   <= 1'b0;
         filled_q <= 1'b0;
         rej_q    <= '0;
         dv_q     <= 1'b0;
         spike_q  <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         tmo_q    <= tmo_d;
         acc_ok_q <= acc_ok_d;
         dist_q   <= dist_d;
         near_q   <= near_d;
         filled_q <= filled_d;
         rej_q    <= rej_d;
         dv_q     <= dv_d;
         spike_q  <= spike_d;
         // Registered so echo_ready reads 0 while reset is held.
         rdy_q    <= (state_d == ST_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      end else if (ring_we) begin
         ring_q[wr_ptr_q] <= raw;
      end
   end

   assign echo_ready = rdy_q;
   assign dist_cm    = dist_q;
   assign dist_valid = dv_q;
   assign near       = near_q;
   assign filled     = filled_q;
   assign spike      = spike_q;
endmodule

// File: tb/tb_us_distance_filter.sv
`timescale 1ns/1ps
module tb_us_distance_filter;
   localparam int WIN = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] echo_cycles;
   logic        echo_timeout, echo_valid, echo_ready;
   logic [15:0] dist_cm;
   logic        dist_valid, near, filled, spike;

   int n_vec = 0, n_err = 0;

   // reference model state
   int win[$];
   int n_acc, m_dist, m_near, m_filled, m_rej;

   us_distance_filter dut (
      .clk(clk), .reset_n(reset_n), .echo_cycles(echo_cycles),
      .echo_timeout(echo_timeout), .echo_valid(echo_valid),
      .echo_ready(echo_ready), .dist_cm(dist_cm), .dist_valid(dist_valid),
      .near(near), .filled(filled), .spike(spike)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      win.delete();
      for (int i = 0; i < WIN; i++) win.push_back(0);
      n_acc = 0; m_dist = 0; m_near = 0; m_filled = 0; m_rej = 0;
   endtask

   // One sample through the model: returns whether dist_valid is due and
   // whether the sample was dropped as an outlier.
   task automatic model_step(input logic [31:0] cyc, input bit tmo,
                             output bit exp_v, output bit rej);
      int raw, sum, d;
      raw = tmo ? 400 : ((cyc / 2900) > 400 ? 400 : int'(cyc / 2900));
      rej = 0;
      exp_v = 0;
`ifdef US_SPIKE_REJECT_EN
      d = raw - m_dist;
      if (d < 0) d = -d;
      if (m_filled != 0 && d > 50 && m_rej < 3) begin
         rej = 1;
         m_rej++;
      end
`else
      d = 0;
`endif
      if (!rej) begin
         m_rej = 0;
         win.push_back(raw);
         void'(win.pop_front());
         n_acc++;
         sum = 0;
         foreach (win[i]) sum += win[i];
         m_dist = sum / WIN;
         if (n_acc >= WIN) begin
            m_filled = 1;
            exp_v = 1;
            if (m_dist <= 20) m_near = 1;
            else if (m_dist >= 25) m_near = 0;
         end
      end
   endtask

   task automatic wait_ready(output bit ok);
      int w = 0;
      while (!echo_ready && w < 100) begin @(negedge clk); w++; end
      ok = echo_ready;
      if (!ok) chk("ready_wait", 0, 1);
   endtask

   task automatic do_sample(input logic [31:0] cyc, input bit tmo);
      bit ok, exp_v, rej;
      int lat, vat, sat, rat, vcnt, scnt, cap_d, cap_n, cap_f;
      lat = tmo ? 3 : 35;
      vat = 0; sat = 0; rat = 0; vcnt = 0; scnt = 0;
      cap_d = 0; cap_n = 0; cap_f = 0;
      wait_ready(ok);
      if (!ok) return;
      model_step(cyc, tmo, exp_v, rej);
      echo_valid = 1'b1; echo_cycles = cyc; echo_timeout = tmo;
      @(posedge clk); #1;
      echo_valid = 1'b0;
      for (int k = 1; k <= 37; k++) begin
         @(negedge clk);
         if (dist_valid) begin
            vcnt++;
            if (vat == 0) begin
               vat = k; cap_d = dist_cm; cap_n = near; cap_f = filled;
            end
         end
         if (spike) begin scnt++; if (sat == 0) sat = k; end
         if (echo_ready && rat == 0) rat = k;
         // junk while busy must be ignored
         if (k < lat) begin
            echo_valid = 1'($urandom); echo_cycles = $urandom;
            echo_timeout = 1'($urandom);
         end else echo_valid = 1'b0;
      end
      chk("ready_ret", rat, lat);
      chk("dv_count", vcnt, exp_v ? 1 : 0);
      if (exp_v) begin
         chk("dv_lat", vat, lat);
         chk("dv_dist", cap_d, m_dist);
         chk("dv_near", cap_n, m_near);
         chk("dv_filled", cap_f, 1);
      end
      chk("spike_cnt", scnt, rej ? 1 : 0);
      if (rej) chk("spike_lat", sat, lat - 1);
      chk("dist_hold", dist_cm, m_dist);
      chk("near_hold", near, m_near);
      chk("filled_hold", filled, m_filled);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_dist"}, dist_cm, 0);
      chk({tag, "_dv"}, dist_valid, 0);
      chk({tag, "_near"}, near, 0);
      chk({tag, "_filled"}, filled, 0);
      chk({tag, "_spike"}, spike, 0);
      chk({tag, "_ready"}, echo_ready, 0);
   endtask

   task automatic b2b();
      bit ok, ev, rj;
      int t = 0, last = 0, hs = 0;
      wait_ready(ok);
      if (!ok) return;
      echo_valid = 1'b1;
      while (hs < 3 && t < 200) begin
         if (echo_ready) begin
            echo_cycles = 58000; echo_timeout = 1'b0;
            if (hs > 0) chk("b2b_gap", t - last, 35);
            last = t;
            hs++;
         end else begin
            echo_cycles = $urandom; echo_timeout = 1'($urandom);
         end
         if (hs < 3) begin @(negedge clk); t++; end
      end
      chk("b2b_hs", hs, 3);
      @(posedge clk); #1;
      echo_valid = 1'b0;
      for (int i = 0; i < hs; i++) model_step(58000, 1'b0, ev, rj);
      repeat (40) @(negedge clk);
      chk("b2b_dist", dist_cm, m_dist);
      chk("b2b_near", near, m_near);
      chk("b2b_filled", filled, m_filled);
   endtask

   function automatic logic [31:0] rnd_cyc(output bit tmo);
      int r = int'($urandom_range(0, 7));
      tmo = (r == 0);
      if (r == 1) return $urandom;
      return $urandom_range(40000, 120000);
   endfunction

   initial begin
      bit ok, tmo;
      logic [31:0] c;
      reset_n = 1'b0; echo_valid = 1'b0; echo_cycles = '0; echo_timeout = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_zero("rst");
      reset_n = 1'b1;
      @(negedge clk);
      chk("rdy_after_rst", echo_ready, 1);

      for (int i = 0; i < 8; i++) do_sample(58000, 1'b0);
      for (int i = 0; i < 8; i++) do_sample(87000, 1'b0);
      do_sample(32'd4000000, 1'b0);
      do_sample(32'd1234, 1'b1);
      b2b();
      for (int i = 0; i < 25; i++) begin
         c = rnd_cyc(tmo);
         do_sample(c, tmo);
      end

      // reset in the middle of a divide
      wait_ready(ok);
      echo_valid = 1'b1; echo_cycles = 58000; echo_timeout = 1'b0;
      @(posedge clk); #1;
      echo_valid = 1'b0;
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk_zero("rst_div");
      reset_n = 1'b1;
      model_reset();

      for (int i = 0; i < 8; i++) do_sample(58000, 1'b0);
      // outlier sequence: single 300 cm, recover, then four in a row
      do_sample(870000, 1'b0);
      do_sample(58000, 1'b0);
      for (int i = 0; i < 4; i++) do_sample(870000, 1'b0);
      do_sample(32'd5, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
